bf16_div: RTL and testbench

- Iterative bfloat16 divider: z = a / b.
- Shares number conventions with the combinational bf16 adder: round toward zero, no subnormals (flush to zero), canonical NaN.
- Sits beside the adder in the arithmetic unit. Unlike the adder it is multi-cycle, with valid/ready handshakes on both sides.
- One divide is in flight at a time.

---
 rtl/bf16_pkg.sv | 18 +
 rtl/bf16_classify.sv | 21 ++
 rtl/bf16_div.sv | 181 ++++++++++++++++++
 tb/tb_bf16_div.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bfloat16 definitions for the arithmetic unit.
//   E, M, BIAS       : bf16 field widths and exponent bias
//   EXP_MAX, NAN_MAN : all-ones exponent and canonical NaN mantissa
//   MAXF_EXP         : exponent of the largest finite value
//   fp_class_t       : operand class produced by bf16_classify
//   div_state_t      : control states of the iterative divider
package bf16_pkg;
  localparam int E    = 8;
  localparam int M    = 7;
  localparam int BIAS = 127;

  localparam logic [E-1:0] EXP_MAX  = 8'hFF;
  localparam logic [E-1:0] MAXF_EXP = 8'hFE;
  localparam logic [M-1:0] NAN_MAN  = 7'h7F;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_t;
endpackage

// File: rtl/bf16_classify.sv
// bf16_classify: combinational class of a bf16 magnitude.
// Ports:
//   e   in  E  exponent field
//   m   in  M  stored mantissa field
//   cls out    FP_ZERO (e==0, subnormals flushed), FP_INF, FP_NAN or FP_NORM
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [E-1:0] e,
  input  logic [M-1:0] m,
  output fp_class_t    cls
);
  always_comb begin
    if (e == '0)
      cls = FP_ZERO;
    else if (e == EXP_MAX)
      cls = (m == '0) ? FP_INF : FP_NAN;
    else
      cls = FP_NORM;
  end
endmodule

// File: rtl/bf16_div.sv
// bf16_div: iterative bfloat16 divider z = a / b, round toward zero,
// subnormals flushed to zero, canonical NaN. One divide in flight.
// Optional macro BF16_DIV_FLAGS_EN adds flags_o = {invalid, divzero,
// overflow, underflow}, registered alongside the result.
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   valid_i / ready_o    operand handshake (ready_o high only when idle)
//   sa_i, ea_i, ma_i     dividend sign / exponent / mantissa
//   sb_i, eb_i, mb_i     divisor sign / exponent / mantissa
//   valid_o / ready_i    result handshake
//   s_o, e_o, m_o        result sign / exponent / mantissa
//   flags_o              exception flags (BF16_DIV_FLAGS_EN only)
module bf16_div
  import bf16_pkg::*;
(
  input  logic         clk,
  input  logic         nreset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o
`ifdef BF16_DIV_FLAGS_EN
  ,
  output logic [3:0]   flags_o
`endif
);
  fp_class_t  cls_a, cls_b;
  div_state_t state_reg;

  logic         sign_reg;
  logic [E-1:0] ea_reg, eb_reg;
  logic [M:0]   divisor_reg;   // {1, mb}
  logic [M+1:0] rem_reg;       // partial remainder, 9 bits
  logic [M+1:0] quo_reg;       // quotient q[8:0], q[8] is the integer bit
  logic [3:0]   cnt_reg;
  logic         s_reg, valid_reg;
  logic [E-1:0] e_reg;
  logic [M-1:0] m_reg;

  bf16_classify u_cls_a (.e(ea_i), .m(ma_i), .cls(cls_a));
  bf16_classify u_cls_b (.e(eb_i), .m(mb_i), .cls(cls_b));

  // Special-operand decode, evaluated on the accept cycle.
  logic         is_special, spec_nan, spec_inf, div_zero;
  logic [E-1:0] spec_e;
  logic [M-1:0] spec_m;

  always_comb begin
    is_special = (cls_a != FP_NORM) || (cls_b != FP_NORM);
    spec_nan   = (cls_a == FP_NAN) || (cls_b == FP_NAN) ||
                 ((cls_a == FP_ZERO) && (cls_b == FP_ZERO)) ||
                 ((cls_a == FP_INF) && (cls_b == FP_INF));
    // Remaining specials: x/0 and inf/x give inf, everything else zero.
    spec_inf   = !spec_nan && ((cls_b == FP_ZERO) || (cls_a == FP_INF));
    div_zero   = (cls_a == FP_NORM) && (cls_b == FP_ZERO);
    spec_e     = (spec_nan || spec_inf) ? EXP_MAX : '0;
    spec_m     = spec_nan ? NAN_MAN : '0;
  end

  // One restoring-division step.
  logic         q_bit;
  logic [M+1:0] rem_sub, rem_next;

  always_comb begin
    q_bit    = (rem_reg >= {1'b0, divisor_reg});
    rem_sub  = q_bit ? (rem_reg - {1'b0, divisor_reg}) : rem_reg;
    // rem_sub < divisor <= 255, so the shifted value still fits 9 bits.
    rem_next = {rem_sub[M:0], 1'b0};
  end

  // Exponent and normalization for the NORM cycle.
  logic signed [9:0] exp_raw, exp_fin;
  logic [M-1:0]      m_norm;
  logic              ovf, unf;

  always_comb begin
    exp_raw = $signed({2'b00, ea_reg}) - $signed({2'b00, eb_reg}) + 10'(BIAS);
    exp_fin = quo_reg[M+1] ? exp_raw : exp_raw - 10'sd1;
    m_norm  = quo_reg[M+1] ? quo_reg[M:1] : quo_reg[M-1:0];
    ovf     = (exp_fin >= 10'sd255);
    unf     = (exp_fin <= 10'sd0);
  end

`ifdef BF16_DIV_FLAGS_EN
  logic [3:0] flags_reg;
  assign flags_o = flags_reg;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      sign_reg    <= 1'b0;
      ea_reg      <= '0;
      eb_reg      <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      s_reg       <= 1'b0;
      e_reg       <= '0;
      m_reg       <= '0;
      valid_reg   <= 1'b0;
`ifdef BF16_DIV_FLAGS_EN
      flags_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            sign_reg    <= sa_i ^ sb_i;
            ea_reg      <= ea_i;
            eb_reg      <= eb_i;
            divisor_reg <= {1'b1, mb_i};
            rem_reg     <= {2'b01, ma_i};
            quo_reg     <= '0;
            cnt_reg     <= '0;
            if (is_special) begin
              s_reg     <= sa_i ^ sb_i;
              e_reg     <= spec_e;
              m_reg     <= spec_m;
              valid_reg <= 1'b1;
`ifdef BF16_DIV_FLAGS_EN
              flags_reg <= {spec_nan, div_zero, 2'b00};
`endif
              state_reg <= DONE;
            end else begin
              state_reg <= DIV;
            end
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= {quo_reg[M:0], q_bit};
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == 4'd8)
            state_reg <= NORM;
        end
        NORM: begin
          s_reg <= sign_reg;
          if (ovf) begin
            e_reg <= MAXF_EXP;
            m_reg <= NAN_MAN;   // all-ones mantissa: largest finite
          end else if (unf) begin
            e_reg <= '0;
            m_reg <= '0;
          end else begin
            e_reg <= exp_fin[E-1:0];
            m_reg <= m_norm;
          end
          valid_reg <= 1'b1;
`ifdef BF16_DIV_FLAGS_EN
          flags_reg <= {2'b00, ovf, unf && !ovf};
`endif
          state_reg <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_reg == IDLE);
  assign valid_o = valid_reg;
  assign s_o     = s_reg;
  assign e_o     = e_reg;
  assign m_o     = m_reg;
endmodule

// File: tb/tb_bf16_div.sv
module tb_bf16_div;
  logic       clk = 1'b0;
  logic       nreset;
  logic       valid_i, ready_i;
  logic       sa_i, sb_i;
  logic [7:0] ea_i, eb_i;
  logic [6:0] ma_i, mb_i;
  logic       ready_o, valid_o, s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;
  logic [3:0] flags_obs;

  always #5 clk = ~clk;

  bf16_div dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
    .sa_i(sa_i), .ea_i(ea_i), .ma_i(ma_i),
    .sb_i(sb_i), .eb_i(eb_i), .mb_i(mb_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .e_o(e_o), .m_o(m_o)
`ifdef BF16_DIV_FLAGS_EN
    , .flags_o(flags_obs)
`endif
  );
`ifndef BF16_DIV_FLAGS_EN
  assign flags_obs = 4'b0000;
`endif

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one divide, wait for its result, compare against the scoreboard.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg, input int lat);
    exp_t e;
    int   got_lat;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    {sa_i, ea_i, ma_i} = a;
    {sb_i, eb_i, mb_i} = b;
    valid_i = 1'b1;
    e.res = res; e.flags = flg; e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1 valid_i = 1'b0;
    got_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid_o) begin
        got_lat = n;
        break;
      end
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"}, 32'(got_lat), 32'(e.lat));
    chk({tag, "_res"}, 32'({s_o, e_o, m_o}), 32'(e.res));
`ifdef BF16_DIV_FLAGS_EN
    chk({tag, "_flags"}, 32'(flags_obs), 32'(e.flags));
`endif
    $display("%s: %h / %h -> %h latency %0d", tag, a, b, {s_o, e_o, m_o}, got_lat);
    if (ready_i) begin
      @(negedge clk);
      chk({tag, "_pulse"}, 32'({valid_o, ready_o}), 32'b01);
    end
  endtask

  initial begin
    nreset = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sa_i = 1'b0; ea_i = '0; ma_i = '0; sb_i = 1'b0; eb_i = '0; mb_i = '0;
    #3;
    chk("reset_outs", 32'({valid_o, ready_o, s_o, e_o, m_o}), 32'h1_0000);
    chk("reset_flags", 32'(flags_obs), 32'h0);
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;

    run_div("div_6_2",   16'h40C0, 16'h4000, 16'h4040, 4'b0000, 11);
    run_div("div_1_3",   16'h3F80, 16'h4040, 16'h3EAA, 4'b0000, 11);
    run_div("div_m1_3",  16'hBF80, 16'h4040, 16'hBEAA, 4'b0000, 11);
    run_div("one_zero",  16'h3F80, 16'h0000, 16'h7F80, 4'b0100, 1);
    run_div("m1_zero",   16'hBF80, 16'h0000, 16'hFF80, 4'b0100, 1);
    run_div("zero_zero", 16'h0000, 16'h0000, 16'h7FFF, 4'b1000, 1);
    run_div("inf_inf",   16'h7F80, 16'h7F80, 16'h7FFF, 4'b1000, 1);
    run_div("one_inf",   16'h3F80, 16'h7F80, 16'h0000, 4'b0000, 1);
    run_div("ovf",       16'h7F00, 16'h3E80, 16'h7F7F, 4'b0010, 11);
    run_div("unf",       16'h0080, 16'h4200, 16'h0000, 4'b0001, 11);

    // Backpressure: result held for 5 cycles, operand pulses ignored.
    ready_i = 1'b0;
    run_div("bp", 16'h40C0, 16'h4000, 16'h4040, 4'b0000, 11);
    for (int i = 0; i < 5; i++) begin
      valid_i = (i == 1 || i == 2);
      {sa_i, ea_i, ma_i} = 16'h3F80;
      {sb_i, eb_i, mb_i} = 16'h0000;
      @(negedge clk);
      chk("bp_hold", 32'({valid_o, ready_o, s_o, e_o, m_o}), 32'h2_4040);
      $display("bp cycle %0d: valid_o=%0d ready_o=%0d z=%h", i, valid_o, ready_o, {s_o, e_o, m_o});
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'({valid_o, ready_o}), 32'b01);
    @(negedge clk);
    chk("bp_idle", 32'({valid_o, ready_o}), 32'b01);

    // Reset asserted four cycles after accept aborts the divide.
    {sa_i, ea_i, ma_i} = 16'h3F80;
    {sb_i, eb_i, mb_i} = 16'h4040;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 nreset = 1'b0;
    #1;
    chk("rst_mid", 32'({valid_o, ready_o}), 32'b01);
    $display("rst_mid: valid_o=%0d ready_o=%0d", valid_o, ready_o);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    chk("rst_no_result", 32'({valid_o, ready_o}), 32'b01);
    run_div("post_rst", 16'h40C0, 16'h4000, 16'h4040, 4'b0000, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
